trenc_atb_sink: RTL and testbench

ATB slave that terminates the trace ATB stream produced by the encoder's ATB master. It is used for on-chip trace capture and as the bench-side checker.
- Accepts ATB beats, filters them by ATID, and serialises the valid bytes one per cycle.
- Reassembles length-prefixed trace packets and presents them on a valid/ready packet port.
- Also drives the ATB flush handshake (afvalid/afready) toward the master.

---
 rtl/trenc_pkg.sv | 14 +
 rtl/trenc_atb_unpack.sv | 72 +++++++
 rtl/trenc_atb_sink.sv | 162 ++++++++++++++++
 tb/tb_trenc_atb_sink.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trenc_pkg.sv
// Shared types and sizing constants for the trace encoder ATB blocks.
package trenc_pkg;

  localparam int unsigned ATBWIDTH      = 32;
  localparam int unsigned MAX_PKT_BYTES = 16;
  localparam int unsigned TRSINK_LEN_W  = $clog2(MAX_PKT_BYTES + 1);

  typedef enum logic [1:0] {
    StHdr,
    StPayload,
    StHold
  } trsink_state_e;

endpackage

// File: rtl/trenc_atb_unpack.sv
// ATB beat staging and ATID filter: turns accepted beats into a stallable
// stream of bytes, lowest byte first.
module trenc_atb_unpack import trenc_pkg::*; #(
  parameter int unsigned AtbWidth = ATBWIDTH
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         atvalid_i,
  output logic                         atready_o,
  input  logic [AtbWidth-1:0]          atdata_i,
  input  logic [$clog2(AtbWidth)-4:0]  atbyte_i,
  input  logic [6:0]                   atid_i,
  input  logic                         en_i,
  input  logic [6:0]                   cfg_atid_i,
  input  logic                         stall_i,
  output logic                         byte_vld_o,
  output logic [7:0]                   byte_o,
  output logic                         drop_o
);

  localparam int unsigned IdxW = $clog2(AtbWidth) - 3;

  logic                stg_vld_q, stg_vld_d;
  logic [AtbWidth-1:0] data_q, data_d;
  logic [IdxW-1:0]     last_q, last_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                at_last, take, accept, load;

  assign at_last    = (idx_q == last_q);
  assign take       = stg_vld_q & ~stall_i;
  // A beat may land in the same cycle the last staged byte leaves.
  assign atready_o  = ~en_i | ~stg_vld_q | (take & at_last);
  assign accept     = atvalid_i & atready_o;
  assign load       = accept & en_i & (atid_i == cfg_atid_i);
  assign drop_o     = accept & ~load;
  assign byte_vld_o = stg_vld_q;
  assign byte_o     = data_q[{idx_q, 3'b000} +: 8];

  always_comb begin
    stg_vld_d = stg_vld_q;
    data_d    = data_q;
    last_d    = last_q;
    idx_d     = idx_q;
    if (load) begin
      stg_vld_d = 1'b1;
      data_d    = atdata_i;
      last_d    = atbyte_i;
      idx_d     = '0;
    end else if (take) begin
      if (at_last) begin
        stg_vld_d = 1'b0;
      end else begin
        idx_d = idx_q + IdxW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stg_vld_q <= 1'b0;
      data_q    <= '0;
      last_q    <= '0;
      idx_q     <= '0;
    end else begin
      stg_vld_q <= stg_vld_d;
      data_q    <= data_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
    end
  end

endmodule

// File: rtl/trenc_atb_sink.sv
// ATB slave terminating the trace stream: reassembles length-prefixed packets,
// keeps statistics and runs the afvalid/afready flush handshake.
module trenc_atb_sink import trenc_pkg::*; #(
  parameter int unsigned AtbWidth    = ATBWIDTH,
  parameter int unsigned MaxPktBytes = MAX_PKT_BYTES,
  parameter int unsigned CntWidth    = 16
) (
  input  logic                               trenc_atclk_i,
  input  logic                               trenc_atrst_i,
  input  logic                               trenc_atvalid_i,
  output logic                               trenc_atready_o,
  input  logic [AtbWidth-1:0]                trenc_atdata_i,
  input  logic [$clog2(AtbWidth)-4:0]        trenc_atbyte_i,
  input  logic [6:0]                         trenc_atid_i,
  output logic                               trenc_afvalid_o,
  input  logic                               trenc_afready_i,
  input  logic                               cfg_en_i,
  input  logic [6:0]                         cfg_atid_i,
  input  logic                               flush_req_i,
  output logic                               flush_done_o,
  output logic                               pkt_vld_o,
  input  logic                               pkt_rdy_i,
  output logic [8*MaxPktBytes-1:0]           pkt_data_o,
  output logic [$clog2(MaxPktBytes+1)-1:0]   pkt_len_o,
  output logic                               err_o,
  input  logic                               err_clr_i,
  output logic [CntWidth-1:0]                pkt_cnt_o,
  output logic [CntWidth-1:0]                drop_cnt_o
);

  localparam int unsigned LenW = $clog2(MaxPktBytes + 1);

  trsink_state_e            state_q, state_d;
  logic [LenW-1:0]          len_q, len_d;
  logic [LenW-1:0]          cnt_q, cnt_d;
  logic [8*MaxPktBytes-1:0] pbuf_q, pbuf_d;
  logic                     pkt_vld_q, pkt_vld_d;
  logic [CntWidth-1:0]      pkt_cnt_q, pkt_cnt_d;
  logic [CntWidth-1:0]      drop_cnt_q, drop_cnt_d;
  logic                     err_q, err_d, err_set;
  logic                     afvalid_q, afvalid_d;
  logic                     flush_done_q, flush_done_d;

  logic       byte_vld, byte_take, drop;
  logic [7:0] byte_data;
  logic       stall;

  assign stall     = (state_q == StHold);
  assign byte_take = byte_vld & ~stall;

  trenc_atb_unpack #(
    .AtbWidth (AtbWidth)
  ) u_unpack (
    .clk_i      (trenc_atclk_i),
    .rst_i      (trenc_atrst_i),
    .atvalid_i  (trenc_atvalid_i),
    .atready_o  (trenc_atready_o),
    .atdata_i   (trenc_atdata_i),
    .atbyte_i   (trenc_atbyte_i),
    .atid_i     (trenc_atid_i),
    .en_i       (cfg_en_i),
    .cfg_atid_i (cfg_atid_i),
    .stall_i    (stall),
    .byte_vld_o (byte_vld),
    .byte_o     (byte_data),
    .drop_o     (drop)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    pbuf_d    = pbuf_q;
    pkt_vld_d = pkt_vld_q;
    pkt_cnt_d = pkt_cnt_q;
    err_set   = 1'b0;
    unique case (state_q)
      StHdr: begin
        if (byte_take) begin
          // A bad header is skipped; the next byte is tried as a header.
          if (byte_data == 8'd0 || 32'(byte_data) > MaxPktBytes) begin
            err_set = 1'b1;
          end else begin
            len_d   = LenW'(byte_data);
            cnt_d   = '0;
            pbuf_d  = '0;
            state_d = StPayload;
          end
        end
      end
      StPayload: begin
        if (byte_take) begin
          for (int unsigned k = 0; k < MaxPktBytes; k++) begin
            if (cnt_q == LenW'(k)) pbuf_d[8*k +: 8] = byte_data;
          end
          cnt_d = cnt_q + LenW'(1);
          if (cnt_q == len_q - LenW'(1)) begin
            state_d   = StHold;
            pkt_vld_d = 1'b1;
            pkt_cnt_d = pkt_cnt_q + CntWidth'(1);
          end
        end
      end
      StHold: begin
        if (pkt_rdy_i) begin
          pkt_vld_d = 1'b0;
          state_d   = StHdr;
        end
      end
      default: state_d = StHdr;
    endcase
  end

  always_comb begin
    err_d        = err_set ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
    drop_cnt_d   = drop ? drop_cnt_q + CntWidth'(1) : drop_cnt_q;
    afvalid_d    = afvalid_q;
    flush_done_d = 1'b0;
    if (!afvalid_q) begin
      if (flush_req_i) afvalid_d = 1'b1;
    end else if (trenc_afready_i) begin
      afvalid_d    = 1'b0;
      flush_done_d = 1'b1;
    end
  end

  always_ff @(posedge trenc_atclk_i) begin
    if (trenc_atrst_i) begin
      state_q      <= StHdr;
      len_q        <= '0;
      cnt_q        <= '0;
      pbuf_q       <= '0;
      pkt_vld_q    <= 1'b0;
      pkt_cnt_q    <= '0;
      drop_cnt_q   <= '0;
      err_q        <= 1'b0;
      afvalid_q    <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      pbuf_q       <= pbuf_d;
      pkt_vld_q    <= pkt_vld_d;
      pkt_cnt_q    <= pkt_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      err_q        <= err_d;
      afvalid_q    <= afvalid_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign pkt_vld_o       = pkt_vld_q;
  assign pkt_data_o      = pbuf_q;
  assign pkt_len_o       = len_q;
  assign err_o           = err_q;
  assign pkt_cnt_o       = pkt_cnt_q;
  assign drop_cnt_o      = drop_cnt_q;
  assign trenc_afvalid_o = afvalid_q;
  assign flush_done_o    = flush_done_q;

endmodule

// File: tb/tb_trenc_atb_sink.sv
// Bench for trenc_atb_sink: queue-based packet model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_trenc_atb_sink;

  logic         clk = 1'b0;
  logic         rst, atvalid, atready, afvalid, afready, en;
  logic [31:0]  atdata;
  logic [1:0]   atbyte;
  logic [6:0]   atid, cfg_atid;
  logic         flush_req, flush_done, pkt_vld, pkt_rdy, err, err_clr;
  logic [127:0] pkt_data;
  logic [4:0]   pkt_len;
  logic [15:0]  pkt_cnt, drop_cnt;

  always #5 clk = ~clk;

  trenc_atb_sink dut (
    .trenc_atclk_i   (clk),
    .trenc_atrst_i   (rst),
    .trenc_atvalid_i (atvalid),
    .trenc_atready_o (atready),
    .trenc_atdata_i  (atdata),
    .trenc_atbyte_i  (atbyte),
    .trenc_atid_i    (atid),
    .trenc_afvalid_o (afvalid),
    .trenc_afready_i (afready),
    .cfg_en_i        (en),
    .cfg_atid_i      (cfg_atid),
    .flush_req_i     (flush_req),
    .flush_done_o    (flush_done),
    .pkt_vld_o       (pkt_vld),
    .pkt_rdy_i       (pkt_rdy),
    .pkt_data_o      (pkt_data),
    .pkt_len_o       (pkt_len),
    .err_o           (err),
    .err_clr_i       (err_clr),
    .pkt_cnt_o       (pkt_cnt),
    .drop_cnt_o      (drop_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: bytes still waiting in staging, bytes still owed to the current packet.
  logic [7:0]  m_q[$];
  int          m_need, m_idx;
  bit          m_hold, m_err, m_afv, m_done;
  logic [4:0]  m_len;
  logic [7:0]  m_data[16];
  logic [15:0] m_pkt_cnt, m_drop_cnt;

  function automatic logic m_atready();
    return !en || m_q.size() == 0 || (!m_hold && m_q.size() == 1);
  endfunction

  function automatic logic [127:0] m_pkt_data();
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[8*k +: 8] = m_data[k];
    return v;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_need = 0; m_idx = 0; m_hold = 0; m_err = 0; m_afv = 0; m_done = 0;
    m_len = '0; m_pkt_cnt = '0; m_drop_cnt = '0;
    for (int k = 0; k < 16; k++) m_data[k] = 8'h00;
  endtask

  task automatic m_step();
    logic       rdy_now, take, eset;
    logic [7:0] b;
    if (rst) begin
      m_reset();
      return;
    end
    rdy_now = m_atready();
    take    = m_q.size() > 0 && !m_hold;
    eset    = 0;
    if (m_hold && pkt_rdy) m_hold = 0;
    if (take) begin
      b = m_q.pop_front();
      if (m_need == 0) begin
        if (b == 0 || b > 16) eset = 1;
        else begin
          m_need = b; m_len = 5'(b); m_idx = 0;
          for (int k = 0; k < 16; k++) m_data[k] = 8'h00;
        end
      end else begin
        m_data[m_idx] = b;
        m_idx++;
        m_need--;
        if (m_need == 0) begin
          m_hold = 1;
          m_pkt_cnt++;
        end
      end
    end
    if (atvalid && rdy_now) begin
      if (en && atid == cfg_atid) for (int k = 0; k <= int'(atbyte); k++) m_q.push_back(atdata[8*k +: 8]);
      else m_drop_cnt++;
    end
    if (eset) m_err = 1;
    else if (err_clr) m_err = 0;
    m_done = 0;
    if (!m_afv) begin
      if (flush_req) m_afv = 1;
    end else if (afready) begin
      m_afv = 0;
      m_done = 1;
    end
  endtask

  task automatic check_all();
    chk("atready", atready, m_atready());
    chk("afvalid", afvalid, m_afv);
    chk("flush_done", flush_done, m_done);
    chk("pkt_vld", pkt_vld, m_hold);
    chk("err", err, m_err);
    chk("pkt_cnt", pkt_cnt, m_pkt_cnt);
    chk("drop_cnt", drop_cnt, m_drop_cnt);
    if (m_hold) begin
      chk("pkt_len", pkt_len, m_len);
      chk("pkt_data", pkt_data, m_pkt_data());
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [1:0] nb, input logic [6:0] id);
    logic acc;
    acc = 0;
    atvalid = 1; atdata = d; atbyte = nb; atid = id;
    for (int i = 0; i < 100 && !acc; i++) begin
      acc = atready;
      step();
    end
    atvalid = 0;
    chk("beat_accept", acc, 1);
  endtask

  task automatic wait_pkt(input int max);
    for (int i = 0; i < max && pkt_vld !== 1'b1; i++) step();
    chk("pkt_wait", pkt_vld, 1);
  endtask

  int hi, dn;

  initial begin
    rst = 1; atvalid = 0; atdata = '0; atbyte = '0; atid = '0; afready = 0; en = 1;
    cfg_atid = 7'h10; flush_req = 0; pkt_rdy = 0; err_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    chk("rst_atready", atready, 1);
    chk("rst_pkt_vld", pkt_vld, 0);
    chk("rst_afvalid", afvalid, 0);
    chk("rst_err", err, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    rst = 0;

    // Single two-byte packet: valid four cycles after acceptance.
    send_beat(32'h00BBAA02, 2'd2, 7'h10);
    step(); step();
    chk("t1_not_yet", pkt_vld, 0);
    step();
    chk("t1_vld", pkt_vld, 1);
    chk("t1_len", pkt_len, 2);
    chk("t1_data", pkt_data, 128'hBBAA);
    chk("t1_cnt", pkt_cnt, 1);
    pkt_rdy = 1; step(); pkt_rdy = 0;

    // Packet spanning two beats, held with a third beat waiting.
    send_beat(32'h33221105, 2'd3, 7'h10);
    send_beat(32'h66015544, 2'd3, 7'h10);
    atvalid = 1; atdata = 32'h0000BC01; atbyte = 2'd1; atid = 7'h10;
    wait_pkt(50);
    for (int i = 0; i < 10; i++) begin
      chk("t2_atready_low", atready, 0);
      chk("t2_data_hold", pkt_data, 128'h5544332211);
      chk("t2_len_hold", pkt_len, 5);
      step();
    end
    pkt_rdy = 1;
    send_beat(32'h0000BC01, 2'd1, 7'h10);
    repeat (8) step();
    chk("t2_pkt_cnt", pkt_cnt, 4);

    // Foreign ATID: accepted and counted as drops.
    for (int i = 0; i < 3; i++) send_beat(32'h01020304, 2'd3, 7'h11);
    chk("t3_drop_cnt", drop_cnt, 3);
    chk("t3_no_pkt", pkt_vld, 0);

    // Bad headers 0x00 and 0x11, then a one-byte packet.
    pkt_rdy = 0;
    send_beat(32'h7E011100, 2'd3, 7'h10);
    wait_pkt(20);
    chk("t4_err", err, 1);
    chk("t4_len", pkt_len, 1);
    chk("t4_data", pkt_data, 128'h7E);
    pkt_rdy = 1; step();
    err_clr = 1; step(); err_clr = 0;
    chk("t4_err_clr", err, 0);

    // Flush with afready four cycles after the request; second request ignored.
    hi = 0; dn = 0;
    for (int i = 0; i < 8; i++) begin
      flush_req = (i == 0 || i == 2);
      afready   = (i == 4);
      hi += int'(afvalid);
      dn += int'(flush_done);
      step();
    end
    flush_req = 0; afready = 0;
    chk("t5_afvalid_cycles", hi, 4);
    chk("t5_done_pulses", dn, 1);

    // Reset mid-payload with a flush outstanding.
    flush_req = 1; step(); flush_req = 0;
    send_beat(32'h33221105, 2'd3, 7'h10);
    step(); step();
    chk("t6_afvalid_pre", afvalid, 1);
    rst = 1; step(); rst = 0;
    chk("t6_atready", atready, 1);
    chk("t6_afvalid", afvalid, 0);
    chk("t6_pkt_vld", pkt_vld, 0);
    chk("t6_pkt_cnt", pkt_cnt, 0);
    chk("t6_drop_cnt", drop_cnt, 0);
    pkt_rdy = 0;
    send_beat(32'h00BBAA02, 2'd2, 7'h10);
    wait_pkt(20);
    chk("t6_data", pkt_data, 128'hBBAA);
    chk("t6_len", pkt_len, 2);
    pkt_rdy = 1; step();

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      atvalid = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) atdata[8*k +: 8] = 8'($urandom_range(0, 18));
      atbyte    = 2'($urandom_range(0, 3));
      atid      = ($urandom_range(0, 7) == 0) ? 7'h11 : 7'h10;
      en        = ($urandom_range(0, 15) != 0);
      pkt_rdy   = ($urandom_range(0, 2) != 0);
      flush_req = ($urandom_range(0, 9) == 0);
      afready   = ($urandom_range(0, 3) == 0);
      err_clr   = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
